// File: rtl/video_src_pkg.sv
// Shared types and constants for the video source generator.
package video_src_pkg;

  typedef enum logic [2:0] {IDLE, VS, VBLK, HS, ACT, HBLK, DONE} state_t;

  typedef enum logic [1:0] {PAT_GRAD, PAT_CHECK, PAT_SOLID, PAT_LFSR} pattern_t;

  localparam logic [23:0] LFSR_SEED = 24'h000001;
  // Right-shift Galois form of x^24+x^23+x^22+x^17+1
  localparam logic [23:0] LFSR_TAPS = 24'hE10000;

  function automatic logic [23:0] lfsr_step(input logic [23:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/video_pattern_gen.sv
// Combinational test-pattern mux with an optional LFSR source.
// LFSR pattern is built only when VIDEO_SRC_LFSR_EN is defined.
module video_pattern_gen import video_src_pkg::*; #(
  parameter logic [23:0] SOLID_RGB = 24'h808080
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  x,
  input  logic [7:0]  y,
  input  pattern_t    pattern,
  input  logic        advance,
  input  logic        reload,
  output logic [23:0] rgb
);

  logic [23:0] lfsr_val;

`ifdef VIDEO_SRC_LFSR_EN
  logic [23:0] lfsr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       lfsr_q <= LFSR_SEED;
    else if (reload)  lfsr_q <= LFSR_SEED;
    else if (advance) lfsr_q <= lfsr_step(lfsr_q);
  end

  assign lfsr_val = lfsr_q;
`else
  logic unused_lfsr;
  assign unused_lfsr = &{1'b0, clk, rst_n, advance, reload};
  assign lfsr_val    = '0;
`endif

  always_comb begin
    rgb = '0;
    unique case (pattern)
      PAT_GRAD:  rgb = {x, y, x + y};
      PAT_CHECK: rgb = {24{x[3] ^ y[3]}};
      PAT_SOLID: rgb = SOLID_RGB;
      PAT_LFSR:  rgb = lfsr_val;
    endcase
  end

endmodule

// File: rtl/video_src_gen.sv
// Frame-timing FSM for a one-shot synthetic pixel stream (vsync/hsync/DE + RGB).
// Optional LFSR pattern enabled by defining VIDEO_SRC_LFSR_EN.
module video_src_gen import video_src_pkg::*; #(
  parameter int unsigned W_LOG2     = 11,
  parameter int unsigned H_LOG2     = 11,
  parameter int unsigned BLANK_LOG2 = 8,
  parameter logic [23:0] SOLID_RGB  = 24'h808080
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [W_LOG2-1:0]     src_width,
  input  logic [H_LOG2-1:0]     src_height,
  input  logic [BLANK_LOG2-1:0] h_blank,
  input  logic [BLANK_LOG2-1:0] v_blank,
  input  logic [1:0]            pattern_sel,
  output logic                  vsync,
  output logic                  hsync,
  output logic                  data_enable,
  output logic [7:0]            cur_R,
  output logic [7:0]            cur_G,
  output logic [7:0]            cur_B,
  output logic                  busy,
  output logic                  frame_sent
);

  state_t                state, state_nxt;
  logic [W_LOG2-1:0]     x_q, x_nxt, w_l;
  logic [H_LOG2-1:0]     y_q, y_nxt, h_l;
  logic [BLANK_LOG2-1:0] b_q, b_nxt, hb_l, vb_l;
  pattern_t              pat_l;
  logic                  cfg_load, line_last;
  logic [23:0]           rgb;

  assign line_last = (y_q == h_l - 1'b1);

  always_comb begin
    state_nxt = state;
    x_nxt     = x_q;
    y_nxt     = y_q;
    b_nxt     = b_q;
    cfg_load  = 1'b0;
    unique case (state)
      IDLE: if (start && src_width != '0 && src_height != '0) begin
        cfg_load  = 1'b1;
        state_nxt = VS;
      end
      VS: begin
        y_nxt     = '0;
        b_nxt     = '0;
        state_nxt = (vb_l != '0) ? VBLK : HS;
      end
      VBLK: if (b_q == vb_l - 1'b1) state_nxt = HS;
            else                    b_nxt     = b_q + 1'b1;
      HS: begin
        x_nxt     = '0;
        state_nxt = ACT;
      end
      ACT: if (x_q == w_l - 1'b1) begin
        b_nxt = '0;
        if (hb_l != '0) state_nxt = HBLK;
        else begin
          state_nxt = line_last ? DONE : HS;
          if (!line_last) y_nxt = y_q + 1'b1;
        end
      end else x_nxt = x_q + 1'b1;
      HBLK: if (b_q == hb_l - 1'b1) begin
        state_nxt = line_last ? DONE : HS;
        if (!line_last) y_nxt = y_q + 1'b1;
      end else b_nxt = b_q + 1'b1;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pixel is generated from the next-cycle column/row so it lands with its strobe.
  video_pattern_gen #(.SOLID_RGB(SOLID_RGB)) u_pat (
    .clk     (clk),
    .rst_n   (rst_n),
    .x       (x_nxt[7:0]),
    .y       (y_nxt[7:0]),
    .pattern (pat_l),
    .advance (state_nxt == ACT),
    .reload  (state_nxt == VS),
    .rgb     (rgb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      b_q         <= '0;
      w_l         <= '0;
      h_l         <= '0;
      hb_l        <= '0;
      vb_l        <= '0;
      pat_l       <= PAT_GRAD;
      vsync       <= 1'b0;
      hsync       <= 1'b0;
      data_enable <= 1'b0;
      busy        <= 1'b0;
      frame_sent  <= 1'b0;
      cur_R       <= '0;
      cur_G       <= '0;
      cur_B       <= '0;
    end else begin
      state <= state_nxt;
      x_q   <= x_nxt;
      y_q   <= y_nxt;
      b_q   <= b_nxt;
      if (cfg_load) begin
        w_l   <= src_width;
        h_l   <= src_height;
        hb_l  <= h_blank;
        vb_l  <= v_blank;
        pat_l <= pattern_t'(pattern_sel);
      end
      vsync       <= (state_nxt == VS);
      hsync       <= (state_nxt == HS);
      data_enable <= (state_nxt == ACT);
      busy        <= !(state_nxt inside {IDLE, DONE});
      frame_sent  <= (state_nxt == DONE);
      {cur_R, cur_G, cur_B} <= (state_nxt == ACT) ? rgb : '0;
    end
  end

endmodule

// File: tb/tb_video_src_gen.sv
// Directed, table-driven bench for video_src_gen with a cycle-indexed timing model.
module tb_video_src_gen;

  localparam logic [23:0] SEED = 24'h000001;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [10:0] src_width, src_height;
  logic [7:0]  h_blank, v_blank;
  logic [1:0]  pattern_sel;
  logic        vsync, hsync, data_enable, busy, frame_sent;
  logic [7:0]  cur_R, cur_G, cur_B;
  logic [28:0] obs;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  video_src_gen dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .src_width   (src_width),
    .src_height  (src_height),
    .h_blank     (h_blank),
    .v_blank     (v_blank),
    .pattern_sel (pattern_sel),
    .vsync       (vsync),
    .hsync       (hsync),
    .data_enable (data_enable),
    .cur_R       (cur_R),
    .cur_G       (cur_G),
    .cur_B       (cur_B),
    .busy        (busy),
    .frame_sent  (frame_sent)
  );

  assign obs = {vsync, hsync, data_enable, busy, frame_sent, cur_R, cur_G, cur_B};

  typedef struct {
    int w, h, hb, vb, pat;
    int fs;
    int de;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] lstep(input logic [23:0] s);
    logic [23:0] n;
    n = {1'b0, s[23:1]};
    if (s[0]) n = n ^ 24'hE10000;
    return n;
  endfunction

  function automatic logic [23:0] pix(input int pat, input int x, input int y, input logic [23:0] lf);
    logic [7:0] xb, yb;
    xb = 8'(x);
    yb = 8'(y);
    case (pat)
      0:       return {xb, yb, 8'(xb + yb)};
      1:       return {24{xb[3] ^ yb[3]}};
      2:       return 24'h808080;
`ifdef VIDEO_SRC_LFSR_EN
      default: return lf;
`else
      default: return 24'h0;
`endif
    endcase
  endfunction

  task automatic run_frame(input vec_t v, input string tag);
    int len, fsm, fs_seen, de_cnt, t, p, lim;
    logic [28:0] e;
    logic [23:0] lf;
    len     = 1 + v.w + v.hb;
    fsm     = 2 + v.vb + v.h * len;
    fs_seen = -1;
    de_cnt  = 0;
    lf      = SEED;
    lim     = (fsm + 3 < 600) ? fsm + 3 : 600;
    @(posedge clk); #1;
    src_width   = 11'(v.w);
    src_height  = 11'(v.h);
    h_blank     = 8'(v.hb);
    v_blank     = 8'(v.vb);
    pattern_sel = 2'(v.pat);
    start       = 1'b1;
    @(posedge clk); #1;
    start       = 1'b0;
    src_width   = 11'($urandom_range(1, 9));
    src_height  = 11'($urandom_range(1, 9));
    h_blank     = 8'($urandom_range(0, 5));
    v_blank     = 8'($urandom_range(0, 5));
    pattern_sel = 2'($urandom_range(0, 3));
    for (int c = 1; c <= lim; c++) begin
      start = (c == 3);
      @(negedge clk);
      e = '0;
      if (c == 1) begin
        e[28] = 1'b1;
        lf    = SEED;
      end
      if (c < fsm)  e[25] = 1'b1;
      if (c == fsm) e[24] = 1'b1;
      if (c >= 2 + v.vb && c < fsm) begin
        t = c - 2 - v.vb;
        p = t % len;
        if (p == 0) e[27] = 1'b1;
        else if (p <= v.w) begin
          e[26]   = 1'b1;
          e[23:0] = pix(v.pat, p - 1, t / len, lf);
          lf      = lstep(lf);
        end
      end
      chk($sformatf("%s c%0d {vs,hs,de,busy,fs,rgb}", tag, c), {3'b0, obs}, {3'b0, e});
      if (obs[26]) de_cnt++;
      if (obs[24] && fs_seen < 0) fs_seen = c;
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk({tag, " frame_sent cycle"}, fs_seen, v.fs);
    chk({tag, " data_enable count"}, de_cnt, v.de);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    src_width   = '0;
    src_height  = '0;
    h_blank     = '0;
    v_blank     = '0;
    pattern_sel = '0;
    vecs[0] = '{4, 2, 2, 3, 0, 19, 8};
    vecs[1] = '{1, 1, 0, 0, 0, 4, 1};
    vecs[2] = '{16, 16, 0, 1, 1, 275, 256};
    vecs[3] = '{3, 2, 1, 0, 2, 12, 6};
    vecs[4] = '{5, 1, 3, 2, 3, 13, 5};
    vecs[5] = '{5, 1, 3, 2, 3, 13, 5};
    vecs[6] = '{2, 3, 0, 2, 3, 13, 6};

    repeat (3) @(posedge clk);
    #1;
    chk("reset outputs", {3'b0, obs}, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

    // Zero width or height: start must be ignored.
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      src_width  = (k == 0) ? 11'd0 : 11'd3;
      src_height = (k == 0) ? 11'd2 : 11'd0;
      h_blank    = 8'd1;
      v_blank    = 8'd1;
      start      = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 1; c <= 8; c++) begin
        @(negedge clk);
        chk($sformatf("zero size %0d c%0d outputs", k, c), {3'b0, obs}, 32'h0);
        @(posedge clk); #1;
      end
    end

    // start held high: a new frame is accepted in the IDLE cycle after DONE.
    src_width   = 11'd1;
    src_height  = 11'd1;
    h_blank     = 8'd0;
    v_blank     = 8'd0;
    pattern_sel = 2'd0;
    start       = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      chk($sformatf("b2b c%0d vsync", c), {31'b0, vsync}, {31'b0, (c == 1 || c == 6)});
      chk($sformatf("b2b c%0d frame_sent", c), {31'b0, frame_sent}, {31'b0, (c == 4 || c == 9)});
      @(posedge clk); #1;
      if (c == 6) start = 1'b0;
    end

    // Asynchronous reset in the middle of an active line.
    @(posedge clk); #1;
    src_width   = 11'd4;
    src_height  = 11'd2;
    h_blank     = 8'd2;
    v_blank     = 8'd3;
    pattern_sel = 2'd0;
    start       = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("pre-reset data_enable", {31'b0, data_enable}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid-frame reset outputs", {3'b0, obs}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-reset idle outputs", {3'b0, obs}, 32'h0);
    run_frame(vecs[0], "after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/video_src_gen.md
Name: video_src_gen

Overview:
- Pixel-stream transmitter that drives the downscaler's input side: vsync, hsync, data_enable and cur_R/G/B.
- Generates one source frame per start request, with programmable active size and blanking.
- Pixel content is a selectable synthetic pattern.
- Used as the stimulus front-end in sim and as an on-chip test source ahead of the downscaler.

Parameters:
- W_LOG2, 11, width of the source column counter and width config.
- H_LOG2, 11, width of the source row counter and height config.
- BLANK_LOG2, 8, width of the blanking-length configs.
- SOLID_RGB, 24'h808080, colour emitted by pattern 2.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request one frame; sampled only in IDLE
- src_width  input  W_LOG2  active pixels per line; latched at start
- src_height  input  H_LOG2  active lines per frame; latched at start
- h_blank  input  BLANK_LOG2  idle cycles after each line's active pixels; latched
- v_blank  input  BLANK_LOG2  idle cycles after vsync, before line 0; latched
- pattern_sel  input  2  0 gradient, 1 checker, 2 solid, 3 LFSR; latched
- vsync  output  1  one-cycle frame-start pulse
- hsync  output  1  one-cycle line-start pulse
- data_enable  output  1  high while cur_R/G/B carry a valid pixel
- cur_R, cur_G, cur_B  output  8 each  pixel data; 0 when data_enable=0
- busy  output  1  high from the vsync cycle through the last cycle of the frame
- frame_sent  output  1  one-cycle pulse on the cycle after the final h_blank cycle

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters 0, LFSR = 24'h000001.
- All outputs are registered.
- FSM states: IDLE, VS, VBLK, HS, ACT, HBLK, DONE.
- IDLE: if start=1 and src_width!=0 and src_height!=0, latch the config and go to VS. Otherwise start is ignored.
- start is ignored in every state other than IDLE.
- VS: vsync=1 for one cycle. Next state is VBLK if v_blank!=0, else HS.
- VBLK: v_blank cycles with all strobes low, then HS.
- HS: hsync=1 for one cycle, then ACT.
  - HS is a separate cycle; it never overlaps data_enable.
- ACT: src_width cycles with data_enable=1, column x = 0..src_width-1.
- HBLK: runs after ACT if h_blank!=0, for h_blank cycles. Next state:
  - HS if row y < src_height-1; y increments here;
  - DONE otherwise.
- DONE: frame_sent=1 for one cycle, busy=0, back to IDLE. A start in the following IDLE cycle is accepted.
- Cycle count per frame: 1 + v_blank + src_height*(1 + src_width + h_blank), plus 1 for DONE.
- Patterns, with x and y truncated to 8 bits:
  - 0: R=x, G=y, B=x+y mod 256.
  - 1: R=G=B = {8{x[3]^y[3]}}.
  - 2: {R,G,B}=SOLID_RGB.
  - 3: see Optional Feature.
- Pixel values are computed combinationally from the next-state counters and registered with data_enable, so the pixel and its strobe align.
- Reset mid-frame: every output drops to 0 immediately (asynchronous). No partial frame resumes.
- Config inputs may change while busy; only the latched copies are used.

Optional Feature:
- Macro: VIDEO_SRC_LFSR_EN.
- Defined: pattern 3 emits {R,G,B} = 24-bit Galois LFSR state, polynomial x^24+x^23+x^22+x^17+1.
  - The LFSR advances only on data_enable cycles.
  - It reloads seed 24'h000001 on each VS.
- Undefined: no LFSR logic; pattern 3 outputs 0 with data_enable still asserted.

Decomposition:
- Package video_src_pkg holds:
  - the state enum (IDLE, VS, VBLK, HS, ACT, HBLK, DONE);
  - the pattern_sel enum;
  - localparam LFSR_SEED and the LFSR tap mask.
- Sub-module video_pattern_gen (combinational pattern mux plus optional LFSR register) takes x, y, pattern, advance and reload. This keeps the FSM and timing counters in video_src_gen.

Test Plan:
- width=4, height=2, h_blank=2, v_blank=3, pattern 0 -> vsync at cycle 1, hsync at cycles 5 and 12, 8 data_enable cycles, R sequence 0,1,2,3,0,1,2,3, G sequence 0x0,0x1, frame_sent at cycle 19.
- v_blank=0, h_blank=0, width=1, height=1 -> vsync, hsync, one pixel, frame_sent on consecutive cycles 1..4; busy high for cycles 1..3.
- start with width=0 -> no strobes and busy stays 0; start pulsed while busy -> ignored, exactly one frame is sent.
- pattern 1, width=16, height=16 -> pixel (8,0)=0xFF, (8,8)=0x00, (0,0)=0x00.
- rst_n low during ACT -> outputs 0 in the same cycle; after release plus start, a full frame is sent with correct counts.
- With VIDEO_SRC_LFSR_EN, pattern 3: first pixel 0x000001, second pixel = one LFSR step, and two back-to-back frames are identical. Without the macro, pattern 3 pixels are all 0.
